down_counter: RTL and testbench
===============================

# down_counter

Handshaked descending index generator: on `start_i` it emits the indices `INPUT_MAX, INPUT_MAX-1, ..., 0`, one per accepted valid/ready transfer. It flags the final index with `last_o` and pulses `done_o` after that index is consumed. It is the reverse-order partner of the ascending address counter in the layer datapath, used wherever a buffer must be read back-to-front, for example FIR/convolution tap reversal. Unlike the free-running ascending counter, it stalls on downstream backpressure.

## Interface
Parameters:
- `WORD_SIZE`, default 16: width of `data_o`.
- `INPUT_MAX`, default 10: first, highest index emitted. Must satisfy 0 ≤ `INPUT_MAX` ≤ 2^`WORD_SIZE`−1, checked by elaboration-time assertion.

Ports:
- `clk_i`, input, 1 bit: clock. Single clock domain.
- `reset_i`, input, 1 bit: reset. Synchronous and active-high.
- `start_i`, input, 1 bit: request a new countdown.
- `ready_i`, input, 1 bit: downstream accepts the current `data_o`.
- `valid_o`, output, 1 bit: `data_o` holds a valid index.
- `data_o`, output, `WORD_SIZE` bits: current index.
- `last_o`, output, 1 bit: the current beat is index 0.
- `busy_o`, output, 1 bit: a countdown is in progress.
- `done_o`, output, 1 bit: one-cycle pulse after the index-0 transfer.

## Operation
- States:
  - `eIDLE`: waiting for `start_i`.
  - `eCOUNTING`: presenting indices.
  - `eDONE`: one-cycle completion state.
- A transfer occurs on a rising edge where `valid_o && ready_i`.
- `eIDLE`:
  - `start_i` = 1 → `eCOUNTING`, with `data_o` loaded to `INPUT_MAX`.
  - `start_i` = 0 → stay in `eIDLE`, with `data_o` = 0.
- `eCOUNTING`:
  - Transfer with `data_o` ≠ 0 → `data_o` decrements by 1; stay in `eCOUNTING`.
  - Transfer with `data_o` = 0 → `eDONE`.
  - No transfer → hold `data_o`. `valid_o` and `data_o` must not change while stalled.
  - `start_i` is ignored in `eCOUNTING`. It is not queued.
- `eDONE`:
  - `start_i` = 1 → `eCOUNTING`, with `data_o` loaded to `INPUT_MAX`. This gives back-to-back runs with one gap cycle.
  - `start_i` = 0 → `eIDLE`, with `data_o` cleared to 0.
- Output decodes:
  - `valid_o` = `busy_o` = (state == `eCOUNTING`).
  - `last_o` = `valid_o && (data_o == 0)`.
  - `done_o` = (state == `eDONE`).
- Arithmetic:
  - Decrement is modulo 2^`WORD_SIZE`. It never actually wraps, because the transition out of `eCOUNTING` happens at 0.
  - `INPUT_MAX` is compared at `WORD_SIZE` bits.
- `INPUT_MAX` = 0: a single beat with `data_o` = 0 and `last_o` = 1 on the same beat.
- Reset:
  - Takes effect at any point, including mid-countdown, at the next rising edge.
  - Forces `eIDLE` and `data_o` = 0.
  - All outputs are 0 after reset.
  - A `start_i` in the same cycle as `reset_i` is discarded.

## Timing
- `start_i` sampled high at edge t (from `eIDLE` or `eDONE`) → from t+1: `valid_o` = 1 and `data_o` = `INPUT_MAX`.
- With `ready_i` held at 1:
  - Indices appear on consecutive cycles t+1 … t+`INPUT_MAX`+1.
  - `last_o` is high on cycle t+`INPUT_MAX`+1.
  - `done_o` is high on cycle t+`INPUT_MAX`+2.
- Throughput: one index per cycle when `ready_i` = 1. Each cycle with `ready_i` = 0 during `eCOUNTING` adds one cycle of latency.
- `ready_i` may change arbitrarily. `valid_o` does not depend combinationally on `ready_i`.
- All outputs are registered state or decoded from state and `data_o` alone. There is no combinational path from input to output.

## Structure
- Shared package `counter_pkg`:
  - The state typedef `enum logic [1:0] {eIDLE, eCOUNTING, eDONE}`.
  - Reused by `up_counter` if it is migrated.
- Single flat module with no sub-modules. It contains:
  - the next-state logic,
  - the state register,
  - the index register with load/decrement/hold/clear mux,
  - the output decodes.

## Test plan
- Reset, then `start_i` for 1 cycle with `INPUT_MAX` = 10 and `ready_i` = 1 → `data_o` = 10,9,…,0 on 11 consecutive cycles. `last_o` only on 0. `done_o` pulses 1 cycle later. Then idle with all outputs 0.
- Same run with `ready_i` toggled 1,0,0,1,… → each index is held stable while stalled, exactly 11 transfers occur, and there are no duplicates or skips.
- `start_i` pulsed mid-countdown (at `data_o` = 5) → ignored. The sequence continues to 0 and there is exactly one `done_o`.
- `start_i` asserted during the `done_o` cycle → `data_o` = 10 with `valid_o` on the next cycle. Two full sequences, separated by one gap cycle.
- `reset_i` asserted at `data_o` = 7 while `ready_i` = 0 → next cycle `valid_o` = 0 and `data_o` = 0, with no `done_o`. A fresh `start_i` restarts at 10.
- `INPUT_MAX` = 0 and `WORD_SIZE` = 4 instance → a single beat with `data_o` = 0 and `last_o` = 1, then `done_o`. Also check `INPUT_MAX` = 15 at `WORD_SIZE` = 4: 16 beats with no wrap.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the layer-datapath index counters (ascending and descending).
package counter_pkg;

  typedef enum logic [1:0] {
    eIDLE     = 2'd0,
    eCOUNTING = 2'd1,
    eDONE     = 2'd2
  } counter_state_e;

endpackage : counter_pkg

// File: rtl/down_counter.sv
// Handshaked descending index generator: emits INPUT_MAX..0, one index per valid/ready transfer.
// All outputs are registered; a stalled beat holds data_o and valid_o until ready_i.
module down_counter
  import counter_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int INPUT_MAX = 10
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam longint MaxRepr = (longint'(1) << WORD_SIZE) - 1;
  localparam logic [WORD_SIZE-1:0] MaxIdx = WORD_SIZE'(INPUT_MAX);
  localparam logic [WORD_SIZE-1:0] One    = WORD_SIZE'(1);

  if ((INPUT_MAX < 0) || (longint'(INPUT_MAX) > MaxRepr)) begin : g_bad_input_max
    $error("down_counter: INPUT_MAX does not fit in WORD_SIZE bits");
  end

  counter_state_e       state_q;
  logic [WORD_SIZE-1:0] cnt_q;
  logic [WORD_SIZE-1:0] cnt_d;
  logic                 valid_q;
  logic                 last_q;
  logic                 done_q;

  // Decrement wraps modulo 2^WORD_SIZE, but the FSM leaves eCOUNTING at 0 before it could.
  always_comb begin
    cnt_d = cnt_q - One;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eIDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        eIDLE, eDONE: begin
          if (start_i) begin
            state_q <= eCOUNTING;
            cnt_q   <= MaxIdx;
            valid_q <= 1'b1;
            last_q  <= (MaxIdx == '0);
          end else begin
            state_q <= eIDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        eCOUNTING: begin
          // start_i is deliberately ignored here; a stall holds every output.
          if (ready_i) begin
            if (cnt_q == '0) begin
              state_q <= eDONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q  <= cnt_d;
              last_q <= (cnt_d == '0);
            end
          end
        end
        default: begin
          state_q <= eIDLE;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  assign busy_o  = valid_q;
  assign data_o  = cnt_q;
  assign last_o  = last_q;
  assign done_o  = done_q;

endmodule : down_counter

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: default, INPUT_MAX=0 and INPUT_MAX=15 (4-bit) instances.
module tb_down_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        start_a = 1'b0, rdy_a = 1'b0;
  logic        start_b = 1'b0, rdy_b = 1'b0;
  logic        start_c = 1'b0, rdy_c = 1'b0;

  logic        valid_a, last_a, busy_a, done_a;
  logic [15:0] data_a;
  logic        valid_b, last_b, busy_b, done_b;
  logic [3:0]  data_b;
  logic        valid_c, last_c, busy_c, done_c;
  logic [3:0]  data_c;

  int errors = 0;
  int checks = 0;

  down_counter #(.WORD_SIZE(16), .INPUT_MAX(10)) u_dut_a (
    .clk_i(clk), .reset_i(rst), .start_i(start_a), .ready_i(rdy_a),
    .valid_o(valid_a), .data_o(data_a), .last_o(last_a), .busy_o(busy_a), .done_o(done_a)
  );

  down_counter #(.WORD_SIZE(4), .INPUT_MAX(0)) u_dut_b (
    .clk_i(clk), .reset_i(rst), .start_i(start_b), .ready_i(rdy_b),
    .valid_o(valid_b), .data_o(data_b), .last_o(last_b), .busy_o(busy_b), .done_o(done_b)
  );

  down_counter #(.WORD_SIZE(4), .INPUT_MAX(15)) u_dut_c (
    .clk_i(clk), .reset_i(rst), .start_i(start_c), .ready_i(rdy_c),
    .valid_o(valid_c), .data_o(data_c), .last_o(last_c), .busy_o(busy_c), .done_o(done_c)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, ".valid"}, int'(valid_a), 0);
    check({tag, ".data"},  int'(data_a),  0);
    check({tag, ".last"},  int'(last_a),  0);
    check({tag, ".busy"},  int'(busy_a),  0);
    check({tag, ".done"},  int'(done_a),  0);
  endtask

  // Caller has already started instance A; the bench tracks the expected beat itself.
  // mode 0: ready always 1; mode 1: ready = 1,0,0,1,0,0...
  // poke >= 0: pulse start_i once while data == poke (must be ignored).
  // restarts: number of start_i pulses issued during done_o cycles.
  task automatic drain_a(input string tag, input int mode, input int poke,
                         input int restarts, input int exp_xfers);
    int  mv = 1;
    int  me = 10;
    int  md = 0;
    int  nmd;
    int  xfers = 0;
    int  dones = 0;
    int  rs_left = restarts;
    bit  poked = 0;
    bit  ended = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      check({tag, ".valid"}, int'(valid_a), mv);
      check({tag, ".busy"},  int'(busy_a),  mv);
      check({tag, ".data"},  int'(data_a),  me);
      check({tag, ".last"},  int'(last_a),  (mv != 0 && me == 0) ? 1 : 0);
      check({tag, ".done"},  int'(done_a),  md);
      if (done_a) dones++;
      if (mv == 0 && md == 0 && rs_left == 0) begin
        ended = 1;
        break;
      end
      start_a = 1'b0;
      if (md != 0 && rs_left > 0) begin
        start_a = 1'b1;
        rs_left--;
      end else if (poke >= 0 && !poked && mv != 0 && me == poke) begin
        start_a = 1'b1;
        poked = 1;
      end
      rdy_a = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (valid_a && rdy_a) xfers++;
      nmd = (mv != 0 && rdy_a && me == 0) ? 1 : 0;
      if (mv == 0 && start_a) begin
        mv = 1;
        me = 10;
      end else if (mv != 0 && rdy_a) begin
        if (me == 0) mv = 0;
        else me--;
      end
      md = nmd;
      tick();
    end
    start_a = 1'b0;
    rdy_a   = 1'b0;
    check({tag, ".timeout"}, int'(ended), 1);
    check({tag, ".xfers"},   xfers, exp_xfers);
    check({tag, ".dones"},   dones, restarts + 1);
  endtask

  initial begin : main
    // Reset, including a start_i coincident with reset that must be dropped.
    rst = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    rst = 1'b0;
    check_idle_a("reset");
    check("reset_b.valid", int'(valid_b), 0);
    check("reset_c.done",  int'(done_c),  0);
    tick();
    check_idle_a("reset_idle");

    // 1: full run, ready held high.
    start_a = 1'b1;
    rdy_a   = 1'b1;
    tick();
    start_a = 1'b0;
    drain_a("run_ready", 0, -1, 0, 11);
    tick();
    check_idle_a("after_run");

    // 2: run with ready 1,0,0,1,...
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    drain_a("run_stall", 1, -1, 0, 11);

    // 3: start_i pulsed at data == 5 is ignored.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    drain_a("run_poke", 0, 5, 0, 11);

    // 4: start_i during done_o gives two back-to-back runs.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    drain_a("run_b2b", 0, -1, 1, 22);

    // 5: reset while stalled at 7.
    start_a = 1'b1;
    rdy_a   = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (valid_a && data_a == 16'd7) break;
      tick();
    end
    rdy_a = 1'b0;
    tick();
    check("stall7.data",  int'(data_a),  7);
    check("stall7.valid", int'(valid_a), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_a("midreset");
    tick();
    check("midreset.nodone", int'(done_a), 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("restart.valid", int'(valid_a), 1);
    check("restart.data",  int'(data_a),  10);

    // INPUT_MAX = 0: one beat that is also last.
    start_b = 1'b1;
    rdy_b   = 1'b1;
    tick();
    start_b = 1'b0;
    check("max0.valid", int'(valid_b), 1);
    check("max0.data",  int'(data_b),  0);
    check("max0.last",  int'(last_b),  1);
    check("max0.done0", int'(done_b),  0);
    tick();
    check("max0.done",  int'(done_b),  1);
    check("max0.end",   int'(valid_b), 0);
    tick();
    check("max0.idle",  int'(done_b),  0);

    // INPUT_MAX = 15 at 4 bits: 16 beats, no wrap.
    start_c = 1'b1;
    rdy_c   = 1'b1;
    tick();
    start_c = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      check("max15.valid", int'(valid_c), 1);
      check("max15.data",  int'(data_c),  i);
      check("max15.last",  int'(last_c),  (i == 0) ? 1 : 0);
      tick();
    end
    check("max15.done",  int'(done_c),  1);
    check("max15.valid", int'(valid_c), 0);
    check("max15.data",  int'(data_c),  0);
    tick();
    check("max15.idle",  int'(busy_c),  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_down_counter
